// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch (IF) and load/store (DM) ports.
// Optional feature: define MEM_ARB_PERF_CNT_EN to add grant/stall performance counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned TIMEOUT_CYC   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_if_stall,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_done_q, if_done_d;
  logic                dm_done_q, dm_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                err_q, err_d;
  logic                grant_dm_c;
  logic                grant_if_c;
  logic                finish_c;
  logic [DATA_W-1:0]   resp_data_c;

  // DM wins a tie unless it has already used up its streak while IF waited
  assign grant_dm_c = (state_q == IDLE) && dm_req &&
                      !(if_req && (streak_q == STREAK_W'(MAX_DM_STREAK)));
  assign grant_if_c = (state_q == IDLE) && if_req && !grant_dm_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = '0;
    dm_rdata_d  = '0;
    err_d       = 1'b0;
    finish_c    = 1'b0;
    resp_data_c = '0;

    case (state_q)
      IDLE: begin
        if (grant_dm_c) begin
          state_d     = BUSY;
          owner_d     = OWN_DM;
          tmo_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_W'(MAX_DM_STREAK)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (grant_if_c) begin
          state_d     = BUSY;
          owner_d     = OWN_IF;
          tmo_d       = '0;
          streak_d    = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          finish_c    = 1'b1;
          resp_data_c = mem_we_q ? '0 : mem_rdata;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          finish_c = 1'b1;
          err_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (finish_c) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          if_done_d  = (owner_q == OWN_IF);
          dm_done_d  = (owner_q == OWN_DM);
          if_rdata_d = (owner_q == OWN_IF) ? resp_data_c : '0;
          dm_rdata_d = (owner_q == OWN_DM) ? resp_data_c : '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        tmo_d   = '0;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants_q;
  logic [31:0] perf_dm_grants_q;
  logic [31:0] perf_if_stall_q;
  logic        serving_if_c;

  // IF counts as served from its grant cycle through its done cycle
  assign serving_if_c = ((state_q != IDLE) && (owner_q == OWN_IF)) || grant_if_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_grants_q <= '0;
      perf_dm_grants_q <= '0;
      perf_if_stall_q  <= '0;
    end else begin
      if (grant_if_c) perf_if_grants_q <= perf_if_grants_q + 32'(1);
      if (grant_dm_c) perf_dm_grants_q <= perf_dm_grants_q + 32'(1);
      if (if_req && !serving_if_c) perf_if_stall_q <= perf_if_stall_q + 32'(1);
    end
  end

  assign perf_if_grants = perf_if_grants_q;
  assign perf_dm_grants = perf_dm_grants_q;
  assign perf_if_stall  = perf_if_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model. Honours MEM_ARB_PERF_CNT_EN when it is defined.
module tb_mem_port_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned TO   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_done, dm_done, err, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_dm_grants, perf_if_stall;
`endif

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
`ifdef MEM_ARB_PERF_CNT_EN
    .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants),
    .perf_if_stall(perf_if_stall),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    tick; tick;
    total++;
    if ({mem_req, mem_we, if_done, dm_done, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b, want 00000", {mem_req, mem_we, if_done, dm_done, err});
    end
    total++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'b0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h %h, want all 0", mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
`ifdef MEM_ARB_PERF_CNT_EN
    total++;
    if ({perf_if_grants, perf_dm_grants, perf_if_stall} !== 96'b0) begin
      bad++;
      $display("FAIL reset_perf: got %0d %0d %0d, want 0 0 0", perf_if_grants, perf_dm_grants, perf_if_stall);
    end
`endif
    rst_n = 1'b1;
    tick;
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_req: got mem_req=%b, want 0", mem_req);
    end
  endtask

  task automatic test_if_read;
    if_req = 1'b1; if_addr = 32'h10;
    tick;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL if_grant: got req=%b addr=%h we=%b, want 1 00000010 0", mem_req, mem_addr, mem_we);
    end
    tick; tick;
    total++;
    if (mem_req !== 1'b1 || if_done !== 1'b0) begin
      bad++;
      $display("FAIL if_wait: got req=%b done=%b, want 1 0", mem_req, if_done);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick;
    total++;
    if (if_done !== 1'b1 || if_rdata !== 32'hDEADBEEF || err !== 1'b0 || dm_done !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL if_done: got done=%b rdata=%h err=%b dm_done=%b req=%b, want 1 deadbeef 0 0 0",
               if_done, if_rdata, err, dm_done, mem_req);
    end
    mem_ack = 1'b0; if_req = 1'b0;
    tick;
    total++;
    if (if_done !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL if_pulse: got done=%b req=%b, want 0 0", if_done, mem_req);
    end
    tick;
  endtask

  task automatic test_both;
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
    tick;
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h55) begin
      bad++;
      $display("FAIL both_dm_first: got req=%b we=%b addr=%h wdata=%h, want 1 1 00000020 00000055",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    tick;
    total++;
    if (dm_done !== 1'b1 || dm_rdata !== 32'h0 || if_done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL both_dm_done: got done=%b rdata=%h if_done=%b err=%b, want 1 0 0 0",
               dm_done, dm_rdata, if_done, err);
    end
    mem_ack = 1'b0; dm_req = 1'b0;
    tick;
    total++;
    if (mem_req !== 1'b0 || dm_done !== 1'b0) begin
      bad++;
      $display("FAIL both_resp_gap: got req=%b dm_done=%b, want 0 0", mem_req, dm_done);
    end
    tick;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h30 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL both_if_next: got req=%b addr=%h we=%b wdata=%h, want 1 00000030 0 0",
               mem_req, mem_addr, mem_we, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    tick;
    total++;
    if (if_done !== 1'b1 || if_rdata !== 32'hCAFE) begin
      bad++;
      $display("FAIL both_if_done: got done=%b rdata=%h, want 1 0000cafe", if_done, if_rdata);
    end
    mem_ack = 1'b0; if_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_streak;
    int n;
    bit got_if, exp_if;
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (mem_req !== 1'b1 && n < 8) begin
        tick;
        n++;
      end
      total++;
      if (n >= 8) begin
        bad++;
        $display("FAIL streak_wait: grant %0d never came, want grant within 8 cycles", g);
      end
      got_if = (mem_addr === 32'h40);
      exp_if = ((g % 5) == 4);
      total++;
      if (got_if !== exp_if) begin
        bad++;
        $display("FAIL streak_order: grant %0d got owner_if=%b, want %b", g, got_if, exp_if);
      end
      mem_ack = 1'b1; mem_rdata = 32'(g);
      tick;
      mem_ack = 1'b0;
      if (!got_if) dm_addr = dm_addr + 32'h4;
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_timeout;
    int n;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; mem_rdata = 32'hBAD0BAD0; mem_ack = 1'b0;
    tick;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      tick;
    end
    total++;
    if (n != TO) begin
      bad++;
      $display("FAIL timeout_len: got %0d busy cycles, want %0d", n, TO);
    end
    total++;
    if (dm_done !== 1'b1 || err !== 1'b1 || dm_rdata !== 32'h0 || if_done !== 1'b0) begin
      bad++;
      $display("FAIL timeout_done: got done=%b err=%b rdata=%h if_done=%b, want 1 1 0 0",
               dm_done, err, dm_rdata, if_done);
    end
    dm_req = 1'b0;
    tick;
    total++;
    if (dm_done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse: got done=%b err=%b, want 0 0", dm_done, err);
    end
    tick;
  endtask

  task automatic test_reset_busy;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h90; dm_wdata = 32'h77;
    tick;
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rb_grant: got mem_req=%b, want 1", mem_req);
    end
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_req, mem_we, dm_done, if_done, err} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL rb_async: got ctrl=%b addr=%h wdata=%h, want all 0",
               {mem_req, mem_we, dm_done, if_done, err}, mem_addr, mem_wdata);
    end
    tick; tick;
    total++;
    if (dm_done !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL rb_no_done: got dm_done=%b req=%b, want 0 0", dm_done, mem_req);
    end
    rst_n = 1'b1;
    tick;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h90 || mem_we !== 1'b1 || mem_wdata !== 32'h77) begin
      bad++;
      $display("FAIL rb_regrant: got req=%b addr=%h we=%b wdata=%h, want 1 00000090 1 00000077",
               mem_req, mem_addr, mem_we, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF;
    tick;
    total++;
    if (dm_done !== 1'b1 || dm_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rb_store_done: got done=%b rdata=%h, want 1 0", dm_done, dm_rdata);
    end
    mem_ack = 1'b0; dm_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_random;
    int own, waited, lat, streak_m, last_own, n_if, n_dm, n_stall;
    bit done_now, gif, served, e_ifd, e_dmd, e_err;
    logic ir, dr, ak, dwe_s, e_we;
    logic [31:0] ia_s, da_s, dwd_s, rd_s, e_addr, e_wd, e_rd;
    own = 0; waited = 0; lat = 0; streak_m = 0; last_own = 0;
    n_if = 0; n_dm = 0; n_stall = 0; done_now = 1'b0;
    e_we = 1'b0; e_addr = '0; e_wd = '0; e_rd = '0;
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_rdata = $urandom;
      if (own != 0) mem_ack = (waited == lat);
      else          mem_ack = ($urandom_range(0, 3) == 0);
      ir = if_req; dr = dm_req; ak = mem_ack; rd_s = mem_rdata;
      ia_s = if_addr; da_s = dm_addr; dwe_s = dm_we; dwd_s = dm_wdata;
      tick;
      // Reference: one access at a time, each done followed by one dead cycle before the next grant
      e_ifd = 1'b0; e_dmd = 1'b0; e_err = 1'b0; gif = 1'b0;
      served = (own == 1) || (done_now && last_own == 1);
      if (done_now) begin
        done_now = 1'b0;
      end else if (own == 0) begin
        if (dr && !(ir && streak_m == MAXS)) begin
          own = 2; n_dm++;
          streak_m = ir ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
          e_we = dwe_s; e_addr = da_s; e_wd = dwd_s;
        end else if (ir) begin
          own = 1; n_if++; gif = 1'b1; streak_m = 0;
          e_we = 1'b0; e_addr = ia_s; e_wd = '0;
        end
        if (own != 0) begin
          waited = 0;
          lat = ($urandom_range(0, 5) == 0) ? 99 : $urandom_range(0, 4);
        end
      end else begin
        waited++;
        if (ak || waited == TO) begin
          e_err = !ak;
          e_rd  = (!ak || (own == 2 && e_we)) ? 32'h0 : rd_s;
          e_ifd = (own == 1);
          e_dmd = (own == 2);
          last_own = own; own = 0; done_now = 1'b1;
        end
      end
      if (ir && !served && !gif) n_stall++;

      total++;
      if (mem_req !== (own != 0)) begin
        bad++;
        $display("FAIL rnd_mem_req: cycle %0d got %b, want %b", c, mem_req, (own != 0));
      end
      if (own != 0) begin
        total++;
        if ({mem_we, mem_addr, mem_wdata} !== {e_we, e_addr, e_wd}) begin
          bad++;
          $display("FAIL rnd_fields: cycle %0d got we=%b addr=%h wdata=%h, want %b %h %h",
                   c, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd);
        end
      end
      total++;
      if (if_done !== e_ifd || dm_done !== e_dmd || err !== e_err) begin
        bad++;
        $display("FAIL rnd_done: cycle %0d got if=%b dm=%b err=%b, want %b %b %b",
                 c, if_done, dm_done, err, e_ifd, e_dmd, e_err);
      end
      if (e_ifd) begin
        total++;
        if (if_rdata !== e_rd) begin
          bad++;
          $display("FAIL rnd_if_rdata: cycle %0d got %h, want %h", c, if_rdata, e_rd);
        end
        if_req = 1'b0;
      end
      if (e_dmd) begin
        total++;
        if (dm_rdata !== e_rd) begin
          bad++;
          $display("FAIL rnd_dm_rdata: cycle %0d got %h, want %h", c, dm_rdata, e_rd);
        end
        dm_req = 1'b0;
      end
    end
`ifdef MEM_ARB_PERF_CNT_EN
    total++;
    if (perf_if_grants !== 32'(n_if) || perf_dm_grants !== 32'(n_dm)) begin
      bad++;
      $display("FAIL perf_grants: got if=%0d dm=%0d, want %0d %0d", perf_if_grants, perf_dm_grants, n_if, n_dm);
    end
    total++;
    if (perf_if_stall !== 32'(n_stall)) begin
      bad++;
      $display("FAIL perf_stall: got %0d, want %0d", perf_if_stall, n_stall);
    end
`endif
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_if_read;
    test_both;
    test_streak;
    test_timeout;
    test_reset_busy;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
